// File: rtl/dram_scan_arbiter.sv
// Shares the single data-RAM port between the CPU and a scan/check engine.
// The engine reads consecutive words once the CPU is inactive and compares them to an arithmetic sequence.
module dram_scan_arbiter #(
  parameter bit SWAP_BYTES = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_active,
  input  logic [31:0]      cpu_data_address,
  input  logic             cpu_data_read,
  input  logic             cpu_data_write,
  input  logic [31:0]      cpu_data_writedata,
  output logic [31:0]      cpu_data_readdata,
  output logic [31:0]      mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_writedata,
  input  logic [31:0]      mem_readdata,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      exp_start,
  input  logic [31:0]      exp_step,
  input  logic [CNT_W-1:0] scan_count,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             aborted,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] fail_index,
  output logic [31:0]      fail_data
);

  typedef enum logic [1:0] {IDLE, WAIT_CPU, SCAN, DONE} state_t;

  state_t           state, state_next;
  logic [31:0]      addr, exp_acc, step;
  logic [CNT_W-1:0] k, count, last_k;
  logic [31:0]      swapped, word;
  logic             mismatch;

  assign swapped  = {mem_readdata[7:0], mem_readdata[15:8], mem_readdata[23:16], mem_readdata[31:24]};
  assign word     = SWAP_BYTES ? swapped : mem_readdata;
  assign mismatch = (word != exp_acc);
  assign last_k   = count - CNT_W'(1);
  assign busy     = (state == WAIT_CPU) || (state == SCAN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = WAIT_CPU;
      WAIT_CPU: if (!cpu_active) state_next = (count == '0) ? DONE : SCAN;
      SCAN:     if (cpu_active || (k == last_k)) state_next = DONE;
      DONE:     if (start) state_next = WAIT_CPU;
      default:  state_next = IDLE;
    endcase
  end

  // Abort takes priority over the compare: an edge that sees the CPU back gets no compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      exp_acc    <= '0;
      step       <= '0;
      count      <= '0;
      k          <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      aborted    <= 1'b0;
      err_count  <= '0;
      fail_index <= '0;
      fail_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr       <= base_addr;
            exp_acc    <= exp_start;
            step       <= exp_step;
            count      <= scan_count;
            k          <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            aborted    <= 1'b0;
            err_count  <= '0;
            fail_index <= '0;
            fail_data  <= '0;
          end
        end
        WAIT_CPU: begin
          if (!cpu_active) begin
            k <= '0;
            if (count == '0) begin
              done <= 1'b1;
              pass <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (cpu_active) begin
            done    <= 1'b1;
            aborted <= 1'b1;
            pass    <= 1'b0;
          end else begin
            if (mismatch) begin
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              if (err_count == '0) begin
                fail_index <= k;
                fail_data  <= word;
              end
            end
            addr    <= addr + 32'd4;
            exp_acc <= exp_acc + step;
            k       <= k + CNT_W'(1);
            if (k == last_k) begin
              done <= 1'b1;
              pass <= !mismatch && (err_count == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_address       = cpu_data_address;
    mem_read          = cpu_data_read;
    mem_write         = cpu_data_write;
    mem_writedata     = cpu_data_writedata;
    cpu_data_readdata = mem_readdata;
    if (state == SCAN) begin
      mem_address       = addr;
      mem_read          = 1'b1;
      mem_write         = 1'b0;
      mem_writedata     = '0;
      cpu_data_readdata = '0;
    end
  end

endmodule

// File: tb/tb_dram_scan_arbiter.sv
// Self-checking bench for dram_scan_arbiter: directed plan cases plus randomized scans
// checked against a loop-based model of the expected scan outcome.
module tb_dram_scan_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_active;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] exp_start;
  logic [31:0] exp_step;
  logic [15:0] scan_count;
  logic        busy;
  logic        done;
  logic        pass;
  logic        aborted;
  logic [15:0] err_count;
  logic [15:0] fail_index;
  logic [31:0] fail_data;

  logic [31:0] ram [0:63];
  int errors = 0;
  int checks = 0;

  assign mem_readdata = ram[mem_address[7:2]];

  always #5 clk = ~clk;

  dram_scan_arbiter #(.SWAP_BYTES(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cpu_active(cpu_active),
    .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(cpu_data_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .start(start), .base_addr(base_addr), .exp_start(exp_start), .exp_step(exp_step),
    .scan_count(scan_count), .busy(busy), .done(done), .pass(pass), .aborted(aborted),
    .err_count(err_count), .fail_index(fail_index), .fail_data(fail_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic fillRam(input logic [31:0] base, input logic [31:0] es, input logic [31:0] step,
                         input int cnt);
    logic [31:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = base + 32'(4 * i);
      ram[a[7:2]] = bswap(es + step * 32'(i));
    end
  endtask

  // Randomize the CPU side and confirm the CPU owns the port.
  task automatic checkPassThrough(input string tag);
    logic [31:0] a;
    cpu_data_address   = $urandom;
    cpu_data_read      = 1'($urandom);
    cpu_data_write     = 1'($urandom);
    cpu_data_writedata = $urandom;
    a = cpu_data_address;
    #1;
    checkOutput({tag, "_addr"}, mem_address, a);
    checkOutput({tag, "_read"}, mem_read, cpu_data_read);
    checkOutput({tag, "_write"}, mem_write, cpu_data_write);
    checkOutput({tag, "_wdata"}, mem_writedata, cpu_data_writedata);
    checkOutput({tag, "_rdata"}, cpu_data_readdata, ram[a[7:2]]);
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] es, input logic [31:0] step,
                               input int cnt, input int abortAt, input int waitCyc);
    int          nComp, expErr, expIdx, scanCyc, engineReads;
    bit          expAbort;
    logic [31:0] expData, a, w, e;

    expAbort = (abortAt >= 0) && (abortAt < cnt);
    nComp    = expAbort ? abortAt : cnt;
    expErr   = 0;
    expIdx   = 0;
    expData  = 32'd0;
    for (int i = 0; i < nComp; i++) begin
      a = base + 32'(4 * i);
      w = bswap(ram[a[7:2]]);
      e = es + step * 32'(i);
      if (w != e) begin
        if (expErr == 0) begin
          expIdx  = i;
          expData = w;
        end
        expErr++;
      end
    end

    @(negedge clk);
    cpu_active = 1'b1;
    start      = 1'b1;
    base_addr  = base;
    exp_start  = es;
    exp_step   = step;
    scan_count = 16'(cnt);
    @(negedge clk);
    start      = 1'b0;
    base_addr  = $urandom;
    exp_start  = $urandom;
    exp_step   = $urandom;
    scan_count = 16'($urandom);
    checkOutput("busy_wait", busy, 1);
    checkOutput("done_cleared", done, 0);
    for (int i = 0; i < waitCyc; i++) begin
      checkPassThrough("wait");
      @(negedge clk);
    end

    cpu_active     = 1'b0;
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
    scanCyc        = 0;
    engineReads    = 0;
    for (int i = 0; i < cnt + 4; i++) begin
      @(negedge clk);
      if (done) break;
      cpu_data_address = $urandom;
      a = base + 32'(4 * scanCyc);
      #1;
      checkOutput("scan_addr", mem_address, a);
      checkOutput("scan_read", mem_read, 1);
      checkOutput("scan_write", mem_write, 0);
      checkOutput("scan_wdata", mem_writedata, 0);
      checkOutput("scan_cpu_rdata", cpu_data_readdata, 0);
      if (mem_read) engineReads++;
      start = (scanCyc == 1);
      if (scanCyc == abortAt) cpu_active = 1'b1;
      scanCyc++;
    end
    start = 1'b0;

    checkOutput("done", done, 1);
    checkOutput("busy_done", busy, 0);
    checkOutput("scan_cycles", scanCyc, expAbort ? abortAt + 1 : cnt);
    checkOutput("engine_reads", engineReads, expAbort ? abortAt + 1 : cnt);
    checkOutput("aborted", aborted, expAbort);
    checkOutput("pass", pass, (expErr == 0) && !expAbort);
    checkOutput("err_count", err_count, expErr);
    checkOutput("fail_index", fail_index, expIdx);
    checkOutput("fail_data", fail_data, expData);
    checkPassThrough("done_port");
    @(negedge clk);
    checkOutput("done_held", done, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          cnt;
    int          abortAt;

    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    reset = 1'b1;
    cpu_active = 1'b1;
    cpu_data_address = 32'd0;
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    cpu_data_writedata = 32'd0;
    start = 1'b0;
    base_addr = 32'd0;
    exp_start = 32'd0;
    exp_step = 32'd0;
    scan_count = 16'd0;
    #3;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_fidx", fail_index, 0);
    checkOutput("rst_fdata", fail_data, 0);
    @(negedge clk);
    reset = 1'b0;
    checkPassThrough("idle");

    $display("[TB] pass path");
    fillRam(32'h480, 32'h12345679, 32'hDCBA1234, 30);
    applyStimulus(32'h480, 32'h12345679, 32'hDCBA1234, 30, -1, 3);
    checkOutput("plan_pass", pass, 1);

    $display("[TB] mismatch path");
    a = 32'h480 + 32'd28;
    ram[a[7:2]] = 32'hDEADBEEF;
    applyStimulus(32'h480, 32'h12345679, 32'hDCBA1234, 30, -1, 1);
    checkOutput("plan_err", err_count, 1);
    checkOutput("plan_fidx", fail_index, 7);
    checkOutput("plan_fdata", fail_data, 32'hEFBEADDE);

    $display("[TB] abort and wrap");
    fillRam(32'hFFFFFFF8, 32'h0000_1000, 32'h0000_0010, 4);
    applyStimulus(32'hFFFFFFF8, 32'h0000_1000, 32'h0000_0010, 4, 2, 2);
    checkOutput("plan_aborted", aborted, 1);
    checkOutput("plan_abort_pass", pass, 0);

    $display("[TB] zero count");
    applyStimulus(32'h100, 32'h5, 32'h7, 0, -1, 2);
    checkOutput("plan_zero_pass", pass, 1);

    $display("[TB] randomized scans");
    for (int r = 0; r < 8; r++) begin
      cnt = $urandom_range(0, 40);
      abortAt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt) : -1;
      a = $urandom & 32'hFFFF_FFFC;
      base_addr = $urandom;
      exp_step = $urandom;
      fillRam(a, base_addr, exp_step, cnt);
      for (int j = 0; j < $urandom_range(0, 3); j++) ram[$urandom_range(0, 63)] = $urandom;
      applyStimulus(a, base_addr, exp_step, cnt, abortAt, $urandom_range(0, 3));
    end

    $display("[TB] reset mid-scan");
    fillRam(32'h480, 32'h12345679, 32'hDCBA1234, 30);
    @(negedge clk);
    cpu_active = 1'b1;
    start = 1'b1;
    base_addr = 32'h480;
    exp_start = 32'h12345679;
    exp_step = 32'hDCBA1234;
    scan_count = 16'd30;
    @(negedge clk);
    start = 1'b0;
    cpu_active = 1'b0;
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_read", mem_read, 1);
    #2;
    cpu_data_address = 32'h0000_0040;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_pass", pass, 0);
    checkOutput("mid_rst_aborted", aborted, 0);
    checkOutput("mid_rst_err", err_count, 0);
    checkOutput("mid_rst_fidx", fail_index, 0);
    checkOutput("mid_rst_fdata", fail_data, 0);
    checkOutput("mid_rst_read", mem_read, 0);
    checkOutput("mid_rst_addr", mem_address, 32'h0000_0040);
    checkOutput("mid_rst_rdata", cpu_data_readdata, ram[16]);
    @(negedge clk);
    reset = 1'b0;
    checkPassThrough("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
